// File: rtl/muldiv_sched.sv
// Round-robin scheduler sharing one multi-cycle mul/div unit between two requesters.
// Latches operands, pulses the unit, and returns the result over a valid/ready channel.
module muldiv_sched #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned OPW  = 5,
  parameter int unsigned CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic            flush0,
  input  logic            flush1,
  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic [XLEN-1:0] resp0_data,
  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic [XLEN-1:0] resp1_data,
  output logic            unit_valid,
  output logic [OPW-1:0]  unit_op,
  output logic [XLEN-1:0] unit_a,
  output logic [XLEN-1:0] unit_b,
  input  logic            unit_data_ok,
  input  logic [XLEN-1:0] unit_res,
  output logic            busy,
  output logic [CNTW-1:0] busy_cycles
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StIssue = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StResp  = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;

  localparam logic [CNTW-1:0] CntOne = {{(CNTW-1){1'b0}}, 1'b1};

  logic [2:0]      state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic v0, v1, gnt1, idle, flush_own, resp_ok, resp_take;

  always_comb begin
    v0        = req0_valid & ~flush0;
    v1        = req1_valid & ~flush1;
    // On a tie, port 1 wins only if port 0 was granted last.
    gnt1      = v1 & (~v0 | ~last_grant_q);
    idle      = (state_q == StIdle);
    req0_ready = idle & v0 & ~gnt1;
    req1_ready = idle & gnt1;
    flush_own = owner_q ? flush1 : flush0;
    resp_ok   = (state_q == StResp) & ~flush_own;
    resp0_valid = resp_ok & ~owner_q;
    resp1_valid = resp_ok & owner_q;
    resp_take = owner_q ? resp1_ready : resp0_ready;
    resp0_data = res_q;
    resp1_data = res_q;
    unit_valid = (state_q == StIssue);
    unit_op    = op_q;
    unit_a     = a_q;
    unit_b     = b_q;
    busy       = ~idle;
    busy_cycles = cnt_q;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    unique case (state_q)
      StIdle: begin
        if (req0_ready | req1_ready) begin
          owner_d      = gnt1;
          last_grant_d = gnt1;
          op_d         = gnt1 ? req1_op : req0_op;
          a_d          = gnt1 ? req1_a : req0_a;
          b_d          = gnt1 ? req1_b : req0_b;
          state_d      = StIssue;
        end
      end
      StIssue: state_d = flush_own ? StDrain : StWait;
      StWait: begin
        if (unit_data_ok) begin
          if (flush_own) begin
            state_d = StIdle;
          end else begin
            res_d   = unit_res;
            state_d = StResp;
          end
        end else if (flush_own) begin
          state_d = StDrain;
        end
      end
      StResp: begin
        if (flush_own | resp_take) state_d = StIdle;
      end
      // The unit cannot be aborted; swallow its eventual result.
      StDrain: begin
        if (unit_data_ok) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (busy && (cnt_q != {CNTW{1'b1}})) cnt_d = cnt_q + CntOne;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: directed timing/flush/reset cases plus
// randomized traffic scored against per-port expected-result queues.
module tb_muldiv_sched;
  localparam int XLEN = 64;
  localparam int OPW  = 5;
  localparam int CNTW = 8;

  logic            clk, rst;
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OPW-1:0]  req0_op, req1_op;
  logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
  logic            flush0, flush1;
  logic            resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [XLEN-1:0] resp0_data, resp1_data;
  logic            unit_valid, unit_data_ok;
  logic [OPW-1:0]  unit_op;
  logic [XLEN-1:0] unit_a, unit_b, unit_res;
  logic            busy;
  logic [CNTW-1:0] busy_cycles;

  int checks = 0;
  int errors = 0;
  int unit_lat = 0;
  logic [XLEN-1:0] q0[$];
  logic [XLEN-1:0] q1[$];
  logic model_busy, model_last;

  muldiv_sched #(.XLEN(XLEN), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .flush0(flush0), .flush1(flush1),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .unit_valid(unit_valid), .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
    .unit_data_ok(unit_data_ok), .unit_res(unit_res),
    .busy(busy), .busy_cycles(busy_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // The unit this bench plays: odd opcodes multiply, even opcodes subtract.
  function automatic logic [XLEN-1:0] ref_f(logic [OPW-1:0] op, logic [XLEN-1:0] a,
                                            logic [XLEN-1:0] b);
    return op[0] ? a * b : a - b;
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    smp();
    while (busy && n < 50) begin
      tick();
      smp();
      n++;
    end
    chk("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  // Unit model: fixed latency when unit_lat>0, else random 1..4 cycles.
  initial begin
    logic pend;
    int cnt;
    logic [XLEN-1:0] res;
    pend = 1'b0;
    cnt = 0;
    res = '0;
    unit_data_ok = 1'b0;
    unit_res = '0;
    forever begin
      smp();
      if (unit_valid) begin
        pend = 1'b1;
        cnt = (unit_lat == 0) ? int'($urandom_range(1, 4)) : unit_lat;
        res = ref_f(unit_op, unit_a, unit_b);
      end
      tick();
      unit_data_ok = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 1'b0;
          unit_data_ok = 1'b1;
          unit_res = res;
        end
      end
    end
  end

  // Response monitor: every presented response must match the owner's queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp0_valid) begin
        if (q0.size() == 0) chk("resp0_unexpected", {63'd0, resp0_valid}, 64'd0);
        else begin
          chk("resp0_data", resp0_data, q0[0]);
          if (resp0_ready) void'(q0.pop_front());
        end
      end
      if (resp1_valid) begin
        if (q1.size() == 0) chk("resp1_unexpected", {63'd0, resp1_valid}, 64'd0);
        else begin
          chk("resp1_data", resp1_data, q1[0]);
          if (resp1_ready) void'(q1.pop_front());
        end
      end
    end
  end

  task automatic run_random(int cycles, int pv, int pr);
    logic acc0, acc1, e0, e1;
    for (int c = 0; c < cycles; c++) begin
      smp();
      e0 = !model_busy && req0_valid && (!req1_valid || model_last);
      e1 = !model_busy && req1_valid && (!req0_valid || !model_last);
      chk("arb_ready0", {63'd0, req0_ready}, {63'd0, e0});
      chk("arb_ready1", {63'd0, req1_ready}, {63'd0, e1});
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (acc0) begin
        q0.push_back(ref_f(req0_op, req0_a, req0_b));
        model_busy = 1'b1;
        model_last = 1'b0;
      end
      if (acc1) begin
        q1.push_back(ref_f(req1_op, req1_a, req1_b));
        model_busy = 1'b1;
        model_last = 1'b1;
      end
      if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) model_busy = 1'b0;
      tick();
      if (acc0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 99) < pv);
        req0_op = OPW'($urandom);
        req0_a = {$urandom, $urandom};
        req0_b = {$urandom, $urandom};
      end
      if (acc1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 99) < pv);
        req1_op = OPW'($urandom);
        req1_a = {$urandom, $urandom};
        req1_b = {$urandom, $urandom};
      end
      resp0_ready = ($urandom_range(0, 99) < pr);
      resp1_ready = ($urandom_range(0, 99) < pr);
    end
  endtask

  initial begin
    int lat;
    int n;
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_op = '0; req1_op = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    flush0 = 0; flush1 = 0; resp0_ready = 0; resp1_ready = 0;
    model_busy = 1'b0;
    model_last = 1'b1;

    // Reset state
    repeat (2) tick();
    smp();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_busy_cycles", 64'(busy_cycles), 64'd0);
    chk("rst_unit_valid", {63'd0, unit_valid}, 64'd0);
    chk("rst_unit_a", unit_a, 64'd0);
    chk("rst_resp0_data", resp0_data, 64'd0);
    tick();
    rst = 1'b0;
    smp();
    chk("post_rst_busy", {63'd0, busy}, 64'd0);

    // Single op: 3*5, unit latency 3
    tick();
    unit_lat = 3; resp0_ready = 1;
    req0_valid = 1; req0_op = 5'd1; req0_a = 64'd3; req0_b = 64'd5;
    smp();
    chk("single_ready", {63'd0, req0_ready}, 64'd1);
    q0.push_back(64'd15);
    tick();
    req0_valid = 0;
    smp();
    chk("single_unit_valid", {63'd0, unit_valid}, 64'd1);
    chk("single_unit_a", unit_a, 64'd3);
    chk("single_unit_b", unit_b, 64'd5);
    chk("single_unit_op", 64'(unit_op), 64'd1);
    lat = 0;
    do begin
      tick();
      smp();
      lat++;
    end while (!resp0_valid && lat < 10);
    chk("single_resp_latency", 64'(lat), 64'd4);
    tick();
    smp();
    chk("single_idle", {63'd0, busy}, 64'd0);
    chk("single_busy_cycles", 64'(busy_cycles), 64'd5);
    chk("single_popped", 64'(q0.size()), 64'd0);

    // Backpressure on port 1 while port 0 waits
    tick();
    resp1_ready = 0;
    req1_valid = 1; req1_op = 5'd0; req1_a = 64'd100; req1_b = 64'd30;
    smp();
    chk("bp_req1_ready", {63'd0, req1_ready}, 64'd1);
    q1.push_back(64'd70);
    tick();
    req1_valid = 0;
    req0_valid = 1; req0_op = 5'd1; req0_a = 64'd7; req0_b = 64'd6;
    n = 0;
    smp();
    while (!resp1_valid && n < 20) begin
      tick();
      smp();
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        tick();
        smp();
      end
      chk("bp_hold_valid", {63'd0, resp1_valid}, 64'd1);
      chk("bp_hold_data", resp1_data, 64'd70);
      chk("bp_req0_blocked", {63'd0, req0_ready}, 64'd0);
    end
    tick();
    resp1_ready = 1;
    smp();
    chk("bp_hs_req0_blocked", {63'd0, req0_ready}, 64'd0);
    tick();
    smp();
    chk("bp_req0_accept", {63'd0, req0_ready}, 64'd1);
    q0.push_back(64'd42);
    tick();
    req0_valid = 0;
    wait_idle();

    // Flush in WAIT, two cycles before data_ok -> drain
    tick();
    unit_lat = 5;
    req0_valid = 1; req0_op = 5'd1; req0_a = 64'd2; req0_b = 64'd2;
    smp();
    chk("fw_ready", {63'd0, req0_ready}, 64'd1);
    tick();
    req0_valid = 0;
    tick();
    tick();
    tick();
    flush0 = 1;
    smp();
    chk("fw_busy_flush", {63'd0, busy}, 64'd1);
    tick();
    flush0 = 0;
    smp();
    chk("fw_busy_drain", {63'd0, busy}, 64'd1);
    tick();
    smp();
    chk("fw_data_ok", {63'd0, unit_data_ok}, 64'd1);
    chk("fw_busy_dok", {63'd0, busy}, 64'd1);
    tick();
    smp();
    chk("fw_idle", {63'd0, busy}, 64'd0);
    chk("fw_no_resp", {63'd0, resp0_valid}, 64'd0);

    // Flush concurrent with data_ok
    tick();
    unit_lat = 3;
    req0_valid = 1; req0_op = 5'd0; req0_a = 64'd9; req0_b = 64'd4;
    smp();
    chk("fd_ready", {63'd0, req0_ready}, 64'd1);
    tick();
    req0_valid = 0;
    tick();
    tick();
    tick();
    flush0 = 1;
    smp();
    chk("fd_data_ok", {63'd0, unit_data_ok}, 64'd1);
    tick();
    flush0 = 0;
    smp();
    chk("fd_idle", {63'd0, busy}, 64'd0);

    // Flush in RESP on port 1
    tick();
    unit_lat = 1; resp1_ready = 0;
    req1_valid = 1; req1_op = 5'd1; req1_a = 64'd5; req1_b = 64'd5;
    smp();
    chk("fr_ready", {63'd0, req1_ready}, 64'd1);
    tick();
    req1_valid = 0;
    tick();
    tick();
    flush1 = 1;
    smp();
    chk("fr_valid_masked", {63'd0, resp1_valid}, 64'd0);
    chk("fr_busy", {63'd0, busy}, 64'd1);
    tick();
    flush1 = 0; resp1_ready = 1;
    smp();
    chk("fr_idle", {63'd0, busy}, 64'd0);

    // Flush blocks own acceptance in IDLE; other port granted
    tick();
    req0_valid = 1; flush0 = 1; req0_op = 5'd1; req0_a = 64'd1; req0_b = 64'd1;
    req1_valid = 1; req1_op = 5'd0; req1_a = 64'd50; req1_b = 64'd8;
    smp();
    chk("fi_ready0", {63'd0, req0_ready}, 64'd0);
    chk("fi_ready1", {63'd0, req1_ready}, 64'd1);
    q1.push_back(64'd42);
    tick();
    req0_valid = 0; flush0 = 0; req1_valid = 0;
    wait_idle();

    // Async reset mid-WAIT, then a stray strobe
    tick();
    unit_lat = 4;
    req0_valid = 1; req0_op = 5'd1; req0_a = 64'd11; req0_b = 64'd3;
    smp();
    chk("ar_ready", {63'd0, req0_ready}, 64'd1);
    tick();
    req0_valid = 0;
    tick();
    #2 rst = 1;
    #1;
    chk("ar_busy", {63'd0, busy}, 64'd0);
    chk("ar_busy_cycles", 64'(busy_cycles), 64'd0);
    chk("ar_unit_a", unit_a, 64'd0);
    chk("ar_unit_op", 64'(unit_op), 64'd0);
    chk("ar_unit_valid", {63'd0, unit_valid}, 64'd0);
    chk("ar_resp0_data", resp0_data, 64'd0);
    chk("ar_resp0_valid", {63'd0, resp0_valid}, 64'd0);
    tick();
    rst = 0;
    tick();
    tick();
    smp();
    chk("ar_stray_dok", {63'd0, unit_data_ok}, 64'd1);
    chk("ar_stray_busy", {63'd0, busy}, 64'd0);
    tick();
    smp();
    chk("ar_stray_after", {63'd0, busy}, 64'd0);
    chk("ar_cnt_after", 64'(busy_cycles), 64'd0);

    // Random phase: first a continuous tie, then mixed traffic
    unit_lat = 0;
    model_busy = 1'b0;
    model_last = 1'b1;
    tick();
    run_random(60, 100, 100);
    run_random(3000, 40, 70);
    req0_valid = 0; req1_valid = 0; resp0_ready = 1; resp1_ready = 1;
    wait_idle();
    repeat (3) tick();
    smp();
    chk("end_q0_empty", 64'(q0.size()), 64'd0);
    chk("end_q1_empty", 64'(q1.size()), 64'd0);
    chk("busy_cycles_sat", 64'(busy_cycles), 64'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Scheduler that shares the single multi-cycle multiply/divide datapath in the execute stage between two requesters (port 0: main issue pipe, port 1: secondary/replay pipe). It arbitrates round-robin, latches operands, issues a one-cycle start pulse to the unit, waits for its completion strobe, and returns the result to the owning requester over a valid/ready response channel. It also handles per-requester flush and keeps a saturating busy-cycle counter for performance monitoring.

## Interface
Parameters:
- XLEN, 64, operand/result width
- OPW, 5, operation code width; passed through unmodified to the unit
- CNTW, 32, width of busy-cycle counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_op / req1_op  in  OPW  operation code
- req0_a, req0_b / req1_a, req1_b  in  XLEN  operands
- flush0 / flush1  in  1  cancel everything owned by that requester
- resp0_valid / resp1_valid  out  1  result available
- resp0_ready / resp1_ready  in  1  requester takes result
- resp0_data / resp1_data  out  XLEN  result
- unit_valid  out  1  start pulse to the mul/div unit
- unit_op  out  OPW; unit_a, unit_b  out  XLEN  latched operation/operands
- unit_data_ok  in  1  unit completion strobe (1 cycle)
- unit_res  in  XLEN  unit result, valid with unit_data_ok
- busy  out  1  state != IDLE
- busy_cycles  out  CNTW  saturating count of non-IDLE cycles

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN. Registers: state, owner (1 bit), last_grant (1 bit), op/a/b latches, result latch.
- IDLE: grant = requester with valid and !flush; if both, the one != last_grant. reqN_ready = (state==IDLE) & grant==N & !flushN; the other ready is 0. On accept: latch op/a/b, owner<=N, last_grant<=N, -> ISSUE.
- ISSUE: unit_valid=1 for exactly this cycle; -> WAIT (or DRAIN if flush[owner]).
- WAIT: on unit_data_ok: latch unit_res, -> RESP; if flush[owner] same cycle -> IDLE, result discarded. flush[owner] without data_ok -> DRAIN.
- DRAIN: unit cannot be aborted; wait for unit_data_ok, discard result, -> IDLE.
- RESP: resp[owner]_valid=1, resp[owner]_data=result latch, held stable until resp[owner]_ready. Handshake -> IDLE. flush[owner] -> IDLE, no handshake occurs (valid forced 0 that cycle).
- Flush of the non-owner has no effect except blocking its own acceptance in IDLE.
- unit_data_ok in IDLE or RESP is ignored (protocol violation, no state change).
- respN_data is driven from the result latch for both ports; only respN_valid distinguishes ownership.
- busy_cycles increments each cycle busy=1, saturates at all-ones, never cleared except by reset.
- Reset (async): state=IDLE, last_grant=1 (port 0 wins first tie), owner=0, all latches 0, busy_cycles=0; all outputs 0.

## Timing
- Accept in cycle T; unit_valid at T+1; unit_data_ok earliest T+2.
- unit_data_ok at cycle D -> respN_valid from D+1.
- Handshake in cycle R -> IDLE at R+1; next accept possible at R+1. Minimum occupancy per op: accept + issue + unit latency + 1 response cycle.
- Flush takes effect the cycle it is asserted (combinational on ready/valid); state changes next edge.
- unit_op/a/b stable from ISSUE until leaving WAIT/DRAIN.
- Reset asserted mid-operation: immediate return to reset values; a late unit_data_ok after reset is ignored (arrives in IDLE).

## Test plan
- Single op: req0 op=MUL a=3 b=5, unit returns 15 three cycles after unit_valid -> unit_valid one cycle after accept, resp0_valid with 15 one cycle after data_ok, busy_cycles=5 after handshake.
- Tie: both req valid from reset, continuously -> grants 0,1,0,1; each resp on the correct port; no ready while busy.
- Backpressure: resp1_ready low 4 cycles -> resp1_valid/data held stable, req0 not accepted until handshake, accepted the following cycle.
- Flush in WAIT: flush0 two cycles before unit_data_ok -> DRAIN, data discarded, resp0_valid never asserted, IDLE one cycle after data_ok.
- Flush in RESP and flush concurrent with data_ok -> no response, IDLE next cycle; flush0 with req0_valid in IDLE -> req0_ready=0, req1 granted if valid.
- Async reset in WAIT, then stray unit_data_ok -> all outputs 0, state IDLE, busy_cycles=0, stray strobe ignored.
